// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer.
// Owns the fetch PC, addresses the combinational instruction memory, and
// buffers fetched words in a circular prefetch queue that decode drains
// through a valid/ready handshake. A taken branch flushes and redirects.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int unsigned DEPTH    = 2      // power of two, >= 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [15:0] fetch_count
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned FCNT_W  = 16;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Queue storage: one {pc, instr} pair per entry.
    logic [31:0] q_pc_q    [DEPTH];
    logic [31:0] q_instr_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [FCNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

    logic        pop_c;
    logic        push_c;
    logic        valid_c;
    logic [31:0] branch_target_c;
    logic        unused_branch_lsbs;

    // Redirect target is always word aligned; the low bits are ignored.
    assign branch_target_c    = {branch_addr[31:2], 2'b00};
    assign unused_branch_lsbs = ^branch_addr[1:0];

    assign valid_c = (count_q != '0);

    // Handshake decode: a branch suppresses both pop and push in its cycle.
    always_comb begin
        pop_c  = 1'b0;
        push_c = 1'b0;
        if (!branch_taken) begin
            pop_c  = valid_c && if_ready;
            push_c = (count_q < FULL_CNT) || pop_c;
        end
    end

    // Next-state for pointers, occupancy, fetch PC and the push counter.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fetch_pc_d  = fetch_pc_q;
        fetch_cnt_d = fetch_cnt_q;
        if (branch_taken) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = branch_target_c;
        end else begin
            if (push_c) begin
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                fetch_pc_d  = fetch_pc_q + PC_STEP;
                fetch_cnt_d = fetch_cnt_q + FCNT_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            fetch_pc_q  <= RESET_PC;
            fetch_cnt_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fetch_pc_q  <= fetch_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Queue storage write; a full queue popping this cycle reuses the head slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else if (push_c) begin
            q_pc_q[wr_ptr_q]    <= fetch_pc_q;
            q_instr_q[wr_ptr_q] <= imem_instr;
        end
    end

    // Head presentation; an empty queue shows a NOP word and the fetch PC.
    always_comb begin
        if_instr = '0;
        if_pc    = fetch_pc_q;
        if (valid_c) begin
            if_instr = q_instr_q[rd_ptr_q];
            if_pc    = q_pc_q[rd_ptr_q];
        end
    end

    assign if_valid    = valid_c;
    assign if_pc_plus4 = if_pc + PC_STEP;
    assign imem_pc     = fetch_pc_q;
    assign fetch_count = fetch_cnt_q;

endmodule
